// File: rtl/sync_fifo_fwft_if.sv
// Bundle of the FIFO's flush, write, read and status signals.
// No logic of its own; timing is set entirely by the FIFO it connects to.
// A write is dropped while full_o=1 and a read is ignored while empty_o=1.
interface sync_fifo_fwft_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
);
  logic                  clr_i;
  logic                  wr_en_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  rd_en_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  almost_full_o;
  logic                  almost_empty_o;
  logic [ADDR_WIDTH:0]   count_o;
  logic                  overflow_o;
  logic                  underflow_o;

  // User side: drives requests and observes data and status.
  modport master (
    output clr_i, wr_en_i, wr_data_i, rd_en_i,
    input  rd_data_o, full_o, empty_o, almost_full_o, almost_empty_o,
           count_o, overflow_o, underflow_o
  );

  // FIFO side: receives requests and produces data and status.
  modport slave (
    input  clr_i, wr_en_i, wr_data_i, rd_en_i,
    output rd_data_o, full_o, empty_o, almost_full_o, almost_empty_o,
           count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO of 2**ADDR_WIDTH words with a standard or first-word-fall-through read port.
// Latency: FWFT=1 shows a written word the next cycle; FWFT=0 updates rd_data_o one cycle after a read.
// Backpressure: a write while full or a read while empty is dropped and latches a sticky error flag.
module sync_fifo_fwft #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  sync_fifo_fwft_if.slave fifo_if
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0]      AE_C    = CNT_W'(AE_THRESH);
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic full;
  logic empty;
  logic wr_acc;
  logic rd_acc;

  // Status is decoded from the registered count so every flag lines up with count_o.
  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  assign wr_acc = fifo_if.wr_en_i & ~full  & ~fifo_if.clr_i;
  assign rd_acc = fifo_if.rd_en_i & ~empty & ~fifo_if.clr_i;

  // Next state of pointers, occupancy and sticky errors; a flush wins over any request.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (fifo_if.clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PTR_ONE;
      if (rd_acc) rptr_d = rptr_q + PTR_ONE;
      if (wr_acc && !rd_acc) begin
        count_d = count_q + CNT_ONE;
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - CNT_ONE;
      end
      if (fifo_if.wr_en_i && full)  ovf_d = 1'b1;
      if (fifo_if.rd_en_i && empty) unf_d = 1'b1;
    end
  end

  // Control state register; reset empties the FIFO without touching the memory.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage array is never reset or flushed; only accepted writes change it.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wptr_q] <= fifo_if.wr_data_i;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word drives the port directly; forced to 0 while empty so reset reads as 0.
      assign fifo_if.rd_data_o = empty ? '0 : mem_q[rptr_q];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

      // Output word loads the head only on an accepted read and holds otherwise.
      always_comb begin
        rdata_d = rdata_q;
        if (fifo_if.clr_i) begin
          rdata_d = '0;
        end else if (rd_acc) begin
          rdata_d = mem_q[rptr_q];
        end
      end

      // Read data register.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rdata_q <= '0;
        end else begin
          rdata_q <= rdata_d;
        end
      end

      assign fifo_if.rd_data_o = rdata_q;
    end
  endgenerate

  assign fifo_if.full_o         = full;
  assign fifo_if.empty_o        = empty;
  assign fifo_if.almost_full_o  = (count_q >= AF_C);
  assign fifo_if.almost_empty_o = (count_q <= AE_C);
  assign fifo_if.count_o        = count_q;
  assign fifo_if.overflow_o     = ovf_q;
  assign fifo_if.underflow_o    = unf_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: a standard-read and a FWFT instance share identical stimulus.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// A queue-based model supplies expected occupancy, flags and read data.
module tb_sync_fifo_fwft;
  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sync_fifo_fwft_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
  sync_fifo_fwft_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

  sync_fifo_fwft #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0),
                   .AF_THRESH(AF), .AE_THRESH(AE))
    u_std (.clk_i(clk), .rst_ni(rst_n), .fifo_if(if0));

  sync_fifo_fwft #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1),
                   .AF_THRESH(AF), .AE_THRESH(AE))
    u_fw (.clk_i(clk), .rst_ni(rst_n), .fifo_if(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents as a queue, plus sticky flags and the standard-mode output word.
  logic [DW-1:0] mq[$];
  bit            m_ovf;
  bit            m_unf;
  logic [DW-1:0] m_rd0;

  typedef struct {
    bit            clr;
    bit            we;
    logic [DW-1:0] wd;
    bit            re;
    int            cnt;
    bit            emp;
    bit            ful;
    bit            ovf;
    bit            unf;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit clr, input bit we, input logic [DW-1:0] wd, input bit re);
    if0.clr_i = clr; if0.wr_en_i = we; if0.wr_data_i = wd; if0.rd_en_i = re;
    if1.clr_i = clr; if1.wr_en_i = we; if1.wr_data_i = wd; if1.rd_en_i = re;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rd0 = '0;
  endtask

  task automatic model_step(input bit clr, input bit we, input logic [DW-1:0] wd, input bit re);
    bit was_full;
    bit was_empty;
    if (clr) begin
      model_reset();
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (we && was_full)  m_ovf = 1'b1;
      if (re && was_empty) m_unf = 1'b1;
      if (re && !was_empty) m_rd0 = mq.pop_front();
      if (we && !was_full)  mq.push_back(wd);
    end
  endtask

  task automatic cyc(input bit clr, input bit we, input logic [DW-1:0] wd, input bit re);
    drive(clr, we, wd, re);
    model_step(clr, we, wd, re);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, "/count0"}, if0.count_o, n);
    chk({tag, "/count1"}, if1.count_o, n);
    chk({tag, "/empty0"}, if0.empty_o, n == 0);
    chk({tag, "/empty1"}, if1.empty_o, n == 0);
    chk({tag, "/full0"},  if0.full_o, n == DEPTH);
    chk({tag, "/full1"},  if1.full_o, n == DEPTH);
    chk({tag, "/afull0"}, if0.almost_full_o, n >= AF);
    chk({tag, "/afull1"}, if1.almost_full_o, n >= AF);
    chk({tag, "/aempty0"}, if0.almost_empty_o, n <= AE);
    chk({tag, "/aempty1"}, if1.almost_empty_o, n <= AE);
    chk({tag, "/ovf0"}, if0.overflow_o, m_ovf);
    chk({tag, "/ovf1"}, if1.overflow_o, m_ovf);
    chk({tag, "/unf0"}, if0.underflow_o, m_unf);
    chk({tag, "/unf1"}, if1.underflow_o, m_unf);
    chk({tag, "/rd0"}, if0.rd_data_o, m_rd0);
    if (n > 0) chk({tag, "/rd1_head"}, if1.rd_data_o, mq[0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wr_pct;
    int rd_pct;
    bit r_clr;
    bit r_we;
    bit r_re;
    total = 0;
    bad   = 0;

    // Reset state.
    rst_n = 1'b0;
    drive(0, 0, '0, 0);
    model_reset();
    #3;
    check_model("reset");
    chk("reset/rd1_zero", if1.rd_data_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vector table, applied from the post-reset empty state.
    tbl[0] = '{0, 1, 16'h1111, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h1111};
    tbl[1] = '{0, 1, 16'h2222, 0, 2, 0, 0, 0, 0, 16'h0000, 16'h1111};
    tbl[2] = '{0, 0, 16'h0000, 1, 1, 0, 0, 0, 0, 16'h1111, 16'h2222};
    tbl[3] = '{0, 1, 16'h3333, 1, 1, 0, 0, 0, 0, 16'h2222, 16'h3333};
    tbl[4] = '{0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 16'h3333, 16'h0000};
    tbl[5] = '{0, 0, 16'h0000, 1, 0, 1, 0, 0, 1, 16'h3333, 16'h0000};
    tbl[6] = '{0, 1, 16'h4444, 1, 1, 0, 0, 0, 1, 16'h3333, 16'h4444};
    tbl[7] = '{1, 1, 16'h5555, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000};
    tbl[8] = '{0, 0, 16'h0000, 1, 0, 1, 0, 0, 1, 16'h0000, 16'h0000};
    tbl[9] = '{0, 0, 16'h0000, 0, 0, 1, 0, 0, 1, 16'h0000, 16'h0000};
    for (int r = 0; r < 10; r++) begin
      drive(tbl[r].clr, tbl[r].we, tbl[r].wd, tbl[r].re);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d/count0", r), if0.count_o, tbl[r].cnt);
      chk($sformatf("tbl%0d/count1", r), if1.count_o, tbl[r].cnt);
      chk($sformatf("tbl%0d/empty", r), if0.empty_o, tbl[r].emp);
      chk($sformatf("tbl%0d/full", r), if0.full_o, tbl[r].ful);
      chk($sformatf("tbl%0d/ovf", r), if0.overflow_o, tbl[r].ovf);
      chk($sformatf("tbl%0d/unf", r), if1.underflow_o, tbl[r].unf);
      chk($sformatf("tbl%0d/rd0", r), if0.rd_data_o, tbl[r].rd0);
      if (!tbl[r].emp) chk($sformatf("tbl%0d/rd1", r), if1.rd_data_o, tbl[r].rd1);
    end

    // Fill to full, then an extra write that must be rejected.
    cyc(1, 0, '0, 0);
    check_model("clr0");
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, DW'(i), 0);
      check_model("fill");
      if (i == 12) chk("fill/af_at13", if0.almost_full_o, 0);
      if (i == 13) chk("fill/af_at14", if0.almost_full_o, 1);
    end
    cyc(0, 1, 16'hBEEF, 0);
    chk("fill/full", if0.full_o, 1);
    chk("fill/overflow", if0.overflow_o, 1);
    chk("fill/count16", if0.count_o, 16);
    check_model("overfill");

    // Drain: standard port shows word i after its read; FWFT port shows it beforehand.
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain/fw_head", if1.rd_data_o, i);
      cyc(0, 0, '0, 1);
      chk("drain/rd0", if0.rd_data_o, i);
      check_model("drain");
    end
    cyc(0, 0, '0, 1);
    chk("drain/underflow", if0.underflow_o, 1);
    chk("drain/empty", if0.empty_o, 1);
    chk("drain/rd0_hold", if0.rd_data_o, 16'h000F);
    check_model("underread");

    // FWFT: word visible without a read request, pop empties it.
    cyc(1, 0, '0, 0);
    cyc(0, 1, 16'hA5A5, 0);
    chk("fwft/empty_low", if1.empty_o, 0);
    chk("fwft/data", if1.rd_data_o, 16'hA5A5);
    cyc(0, 0, '0, 0);
    chk("fwft/data_held", if1.rd_data_o, 16'hA5A5);
    cyc(0, 0, '0, 1);
    chk("fwft/empty_after_pop", if1.empty_o, 1);
    check_model("fwft");

    // Simultaneous read and write at count 8 across pointer wrap.
    cyc(1, 0, '0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, DW'(100 + i), 0);
    for (int k = 0; k < 20; k++) begin
      cyc(0, 1, DW'(108 + k), 1);
      chk("rw/count8", if0.count_o, 8);
      chk("rw/order", if0.rd_data_o, 100 + k);
      check_model("rw");
    end

    // Flush at count 5 together with a write.
    cyc(1, 0, '0, 0);
    cyc(0, 0, '0, 1);
    chk("clr/unf_set", if0.underflow_o, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, DW'(16'h0500 + i), 0);
    chk("clr/count5", if0.count_o, 5);
    cyc(1, 1, 16'hDEAD, 0);
    chk("clr/count0", if0.count_o, 0);
    chk("clr/empty", if1.empty_o, 1);
    chk("clr/unf_cleared", if0.underflow_o, 0);
    chk("clr/rd0_zero", if0.rd_data_o, 0);
    check_model("clr");

    // Asynchronous reset between edges at count 7.
    cyc(0, 0, '0, 1);
    for (int i = 0; i < 7; i++) cyc(0, 1, DW'(16'h0700 + i), 0);
    chk("rst/count7", if0.count_o, 7);
    #3;
    rst_n = 1'b0;
    model_reset();
    #2;
    check_model("rst_async");
    chk("rst/rd1_zero", if1.rd_data_o, 0);
    chk("rst/aempty", if1.almost_empty_o, 1);
    #1;
    rst_n = 1'b1;
    cyc(0, 1, 16'h7777, 0);
    chk("rst/fw_addr0", if1.rd_data_o, 16'h7777);
    cyc(0, 0, '0, 1);
    chk("rst/rd0_new", if0.rd_data_o, 16'h7777);
    check_model("post_rst");

    // Randomized traffic in phases biased toward filling, draining and balance.
    for (int ph = 0; ph < 6; ph++) begin
      case (ph % 3)
        0:       begin wr_pct = 80; rd_pct = 30; end
        1:       begin wr_pct = 30; rd_pct = 80; end
        default: begin wr_pct = 60; rd_pct = 60; end
      endcase
      for (int c = 0; c < 500; c++) begin
        r_clr = ($urandom_range(0, 79) == 0);
        r_we  = ($urandom_range(0, 99) < wr_pct);
        r_re  = ($urandom_range(0, 99) < rd_pct);
        cyc(r_clr, r_we, DW'($urandom), r_re);
        check_model("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
